// File: rtl/rv_pkg.sv
// Shared definitions for the data-memory responder: address map, region select, STATUS layout.
package rv_pkg;

  localparam int XLEN = 32;

  // Address map (byte addresses; decode uses bits [31:2] only)
  localparam logic [31:0] ADDR_RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] ADDR_TXDATA   = 32'h1000_0000;
  localparam logic [31:0] ADDR_STATUS   = 32'h1000_0004;
  localparam logic [31:0] ADDR_MTIME_LO = 32'h1000_0008;
  localparam logic [31:0] ADDR_MTIME_HI = 32'h1000_000C;
  localparam logic [31:0] ADDR_MTCMP_LO = 32'h1000_0010;
  localparam logic [31:0] ADDR_MTCMP_HI = 32'h1000_0014;

  // STATUS register bit positions
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 8;

  typedef enum logic [2:0] {
    RAM,
    TXDATA,
    STATUS,
    MTIME_LO,
    MTIME_HI,
    MTCMP_LO,
    MTCMP_HI,
    NONE
  } dr_sel_e;

  // Region select from the word address; RAM occupies the first ram_words words.
  function automatic dr_sel_e dr_decode(input logic [29:0] word_addr, input int ram_words);
    dr_sel_e sel;
    sel = NONE;
    if ({2'b00, word_addr} < $unsigned(ram_words)) sel = RAM;
    else if (word_addr == ADDR_TXDATA[31:2])        sel = TXDATA;
    else if (word_addr == ADDR_STATUS[31:2])        sel = STATUS;
    else if (word_addr == ADDR_MTIME_LO[31:2])      sel = MTIME_LO;
    else if (word_addr == ADDR_MTIME_HI[31:2])      sel = MTIME_HI;
    else if (word_addr == ADDR_MTCMP_LO[31:2])      sel = MTCMP_LO;
    else if (word_addr == ADDR_MTCMP_HI[31:2])      sel = MTCMP_HI;
    return sel;
  endfunction

  // Replace the strobed bytes of a 32-bit word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] w;
    w = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) w[8*i +: 8] = new_w[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/rv_tx_fifo.sv
// Byte FIFO for the TX path; head byte and empty flag come straight from registers.
module rv_tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [7:0]    head
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          empty_q;
  logic [7:0]    head_q, head_n;
  logic          push_ok, pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign pop_ok  = pop && !empty_q;
  // A push into a full FIFO is still accepted when a pop frees a slot the same edge.
  assign push_ok = push && (!full || pop_ok);

  // Next read pointer, occupancy and head byte
  // NOTE: every always_comb output is given a default first so no latch can be inferred.
  always_comb begin
    rd_ptr_n = rd_ptr + PW'(pop_ok);
    cnt_n    = cnt + CW'(push_ok) - CW'(pop_ok);
    head_n   = mem[rd_ptr_n];
    // The byte being written this edge becomes the head when it lands at the new read slot.
    if (push_ok && (wr_ptr == rd_ptr_n)) head_n = wdata;
  end

  // Entry storage
  // NOTE: storage is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers, count and registered head/empty
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      empty_q <= 1'b1;
      head_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr  <= rd_ptr_n;
      cnt     <= cnt_n;
      empty_q <= (cnt_n == '0);
      head_q  <= head_n;
    end
  end

  assign empty = empty_q;
  assign count = cnt;
  assign head  = head_q;

endmodule

// File: rtl/rv_dmem_responder.sv
// Data-memory responder: byte-strobed word RAM, TX byte FIFO with STATUS, and a 64-bit timer.
module rv_dmem_responder
  import rv_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int TXQ_DEPTH = 8
) (
  input  logic              i_dr_clk,
  input  logic              i_dr_rstn,
  input  logic [XLEN-1:0]   i_dr_addr,
  input  logic              i_dr_wen,
  input  logic [XLEN/8-1:0] i_dr_wstrb,
  input  logic [XLEN-1:0]   i_dr_wdata,
  output logic [XLEN-1:0]   o_dr_rdata,
  output logic              o_dr_tx_valid,
  output logic [7:0]        o_dr_tx_data,
  input  logic              i_dr_tx_ready,
  output logic              o_dr_timer_irq
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(TXQ_DEPTH) + 1;

  dr_sel_e           sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [XLEN-1:0]   ram [RAM_WORDS];
  logic [1:0]        unused_addr_bits;

  logic              push_req, pop, ovf_set, ovf_clr, ovf;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        fifo_head;

  logic [63:0]       mtime, mtime_n, mtcmp, mtcmp_n;
  logic [XLEN-1:0]   status;

  assign sel              = dr_decode(i_dr_addr[XLEN-1:2], RAM_WORDS);
  assign ram_idx          = i_dr_addr[RAM_AW+1:2];
  assign unused_addr_bits = i_dr_addr[1:0];

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge i_dr_clk) begin
    if (i_dr_wen && sel == RAM) begin
      for (int i = 0; i < XLEN/8; i++) begin
        if (i_dr_wstrb[i]) ram[ram_idx][8*i +: 8] <= i_dr_wdata[8*i +: 8];
      end
    end
  end

  assign push_req = i_dr_wen && (sel == TXDATA) && i_dr_wstrb[0];
  assign pop      = o_dr_tx_valid && i_dr_tx_ready;
  // A push into a full FIFO is lost only when no pop makes room that edge.
  assign ovf_set  = push_req && fifo_full && !pop;
  assign ovf_clr  = i_dr_wen && (sel == STATUS) && i_dr_wstrb[0] && i_dr_wdata[STATUS_OVF_BIT];

  rv_tx_fifo #(
    .DEPTH (TXQ_DEPTH)
  ) u_tx_fifo (
    .clk   (i_dr_clk),
    .rst_n (i_dr_rstn),
    .push  (push_req),
    .pop   (pop),
    .wdata (i_dr_wdata[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign o_dr_tx_valid = !fifo_empty;
  assign o_dr_tx_data  = fifo_head;

  // Next timer values: free-running count unless software writes a half of mtime
  always_comb begin
    mtime_n = mtime + 64'd1;
    mtcmp_n = mtcmp;
    if (i_dr_wen) begin
      case (sel)
        MTIME_LO: mtime_n = {mtime[63:32], merge_bytes(mtime[31:0], i_dr_wdata, i_dr_wstrb)};
        MTIME_HI: mtime_n = {merge_bytes(mtime[63:32], i_dr_wdata, i_dr_wstrb), mtime[31:0]};
        MTCMP_LO: mtcmp_n = {mtcmp[63:32], merge_bytes(mtcmp[31:0], i_dr_wdata, i_dr_wstrb)};
        MTCMP_HI: mtcmp_n = {merge_bytes(mtcmp[63:32], i_dr_wdata, i_dr_wstrb), mtcmp[31:0]};
        default: ;
      endcase
    end
  end

  // Timer, compare, interrupt and overflow-flag registers
  always_ff @(posedge i_dr_clk or negedge i_dr_rstn) begin
    if (!i_dr_rstn) begin
      mtime          <= '0;
      mtcmp          <= '1;
      o_dr_timer_irq <= 1'b0;
      ovf            <= 1'b0;
    end else begin
      mtime          <= mtime_n;
      mtcmp          <= mtcmp_n;
      o_dr_timer_irq <= (mtime >= mtcmp);
      // Overflow wins over a software clear landing on the same edge.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // STATUS word assembly
  always_comb begin
    status                                      = '0;
    status[STATUS_FULL_BIT]                     = fifo_full;
    status[STATUS_EMPTY_BIT]                    = fifo_empty;
    status[STATUS_OVF_BIT]                      = ovf;
    status[STATUS_COUNT_LSB +: STATUS_COUNT_W]  = STATUS_COUNT_W'(fifo_count);
  end

  // Combinational read mux; TXDATA and unmapped regions read as zero
  always_comb begin
    o_dr_rdata = '0;
    case (sel)
      RAM:      o_dr_rdata = ram[ram_idx];
      STATUS:   o_dr_rdata = status;
      MTIME_LO: o_dr_rdata = mtime[31:0];
      MTIME_HI: o_dr_rdata = mtime[63:32];
      MTCMP_LO: o_dr_rdata = mtcmp[31:0];
      MTCMP_HI: o_dr_rdata = mtcmp[63:32];
      default:  o_dr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Self-checking bench for rv_dmem_responder: directed scenarios plus randomized traffic
// checked against a queue/array/arithmetic reference model.
module tb_rv_dmem_responder;
  import rv_pkg::*;

  localparam int RAM_WORDS = 1024;
  localparam int TXQ_DEPTH = 8;
  localparam int HALF      = 50;

  logic        clk      = 1'b0;
  logic        rstn     = 1'b0;
  logic [31:0] addr     = '0;
  logic        wen      = 1'b0;
  logic [3:0]  wstrb    = '0;
  logic [31:0] wdata    = '0;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #HALF clk = ~clk;

  rv_dmem_responder #(
    .RAM_WORDS (RAM_WORDS),
    .TXQ_DEPTH (TXQ_DEPTH)
  ) dut (
    .i_dr_clk       (clk),
    .i_dr_rstn      (rstn),
    .i_dr_addr      (addr),
    .i_dr_wen       (wen),
    .i_dr_wstrb     (wstrb),
    .i_dr_wdata     (wdata),
    .o_dr_rdata     (rdata),
    .o_dr_tx_valid  (tx_valid),
    .o_dr_tx_data   (tx_data),
    .i_dr_tx_ready  (tx_ready),
    .o_dr_timer_irq (irq)
  );

  // Expected STATUS word from a queue occupancy and overflow flag
  function automatic logic [31:0] exp_status(input int cnt, input logic ovf_f);
    logic [31:0] s;
    s       = 32'h0;
    s[0]    = (cnt == TXQ_DEPTH);
    s[1]    = (cnt == 0);
    s[2]    = ovf_f;
    s[15:8] = 8'(cnt);
    return s;
  endfunction

  // One write spanning exactly one rising edge; called just after a falling edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr  = a;
    wdata = d;
    wstrb = s;
    wen   = 1'b1;
    @(negedge clk);
    wen   = 1'b0;
    wstrb = 4'h0;
  endtask

  // Combinational read, no clock edge consumed
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    wen  = 1'b0;
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic do_reset();
    wen      = 1'b0;
    tx_ready = 1'b0;
    rstn     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rstn = 1'b0;
    #(3*HALF);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    @(negedge clk);
    rstn = 1'b1;
    bus_read(ADDR_MTIME_LO, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mtime_lo got %h exp 0", d); end
    bus_read(ADDR_MTIME_HI, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mtime_hi got %h exp 0", d); end
    bus_read(ADDR_MTCMP_LO, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_mtcmp_lo got %h exp ffffffff", d); end
    bus_read(ADDR_MTCMP_HI, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_mtcmp_hi got %h exp ffffffff", d); end
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp 00000002", d); end
    bus_read(ADDR_TXDATA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL read_txdata got %h exp 0", d); end
    bus_read(32'h2000_0000, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL read_unmapped got %h exp 0", d); end
  endtask

  task automatic test_ram_strobe();
    logic [31:0] d;
    @(negedge clk);
    bus_write(32'h40, 32'h0, 4'hF);
    // Strobed write; the same-cycle read must still see the old word
    addr = 32'h40; wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wen = 1'b1;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL ram_same_cycle_read got %h exp 0", rdata); end
    @(negedge clk);
    wen = 1'b0; wstrb = 4'h0;
    bus_read(32'h40, d);
    checks++; if (d !== 32'h00BB_00DD) begin errors++; $display("FAIL ram_strobe got %h exp 00bb00dd", d); end
    bus_read(32'h43, d);
    checks++; if (d !== 32'h00BB_00DD) begin errors++; $display("FAIL ram_low_addr_bits got %h exp 00bb00dd", d); end
    // Top word of RAM, word 0, and the first byte address past RAM
    bus_write(32'(4*RAM_WORDS - 4), 32'h1234_5678, 4'hF);
    bus_write(32'h0, 32'hCAFE_F00D, 4'hF);
    bus_write(32'(4*RAM_WORDS), 32'hDEAD_BEEF, 4'hF);
    bus_read(32'(4*RAM_WORDS - 4), d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_last_word got %h exp 12345678", d); end
    bus_read(32'(4*RAM_WORDS), d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ram_past_end got %h exp 0", d); end
    bus_read(32'h0, d);
    checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_no_alias got %h exp cafef00d", d); end
  endtask

  task automatic test_ram_random();
    logic [31:0] mdl [int];
    int          keys [16];
    int          k;
    logic [31:0] d, v;
    logic [3:0]  s;
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, RAM_WORDS - 1);
      v = $urandom();
      keys[i] = k;
      mdl[k]  = v;
      bus_write(32'(k*4), v, 4'hF);
    end
    for (int n = 0; n < 60; n++) begin
      k = keys[$urandom_range(0, 15)];
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom();
        s = 4'($urandom());
        for (int b = 0; b < 4; b++) if (s[b]) mdl[k][8*b +: 8] = v[8*b +: 8];
        bus_write(32'(k*4 + int'($urandom_range(0, 3))), v, s);
      end else begin
        bus_read(32'(k*4), d);
        checks++; if (d !== mdl[k]) begin errors++; $display("FAIL ram_random word %0d got %h exp %h", k, d, mdl[k]); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_fifo_overflow();
    logic [7:0]  b [9];
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b[i] = 8'($urandom());
      d = $urandom();
      d[7:0] = b[i];
      bus_write(ADDR_TXDATA, d, 4'b0001);
    end
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0000_0805) begin errors++; $display("FAIL ovf_status got %h exp 00000805", d); end
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL ovf_head_valid got %b exp 1", tx_valid); end
    checks++; if (tx_data !== b[0]) begin errors++; $display("FAIL ovf_head got %h exp %h", tx_data, b[0]); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== b[i])
        begin errors++; $display("FAIL drain_%0d got v=%b %h exp v=1 %h", i, tx_valid, tx_data, b[i]); end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_falls got %b exp 0", tx_valid); end
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL drained_status got %h exp 00000006", d); end
    bus_write(ADDR_STATUS, 32'h4, 4'b0001);
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ovf_clear got %h exp 00000002", d); end
    // A TXDATA write without lane 0 strobed must not push
    bus_write(ADDR_TXDATA, 32'h5555_5555, 4'b1110);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL no_push_without_strb0 got %b exp 0", tx_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0]  b [8];
    logic [7:0]  nb;
    logic [7:0]  exp_q [$];
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b[i] = 8'($urandom());
      bus_write(ADDR_TXDATA, {24'h0, b[i]}, 4'b0001);
    end
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0000_0801) begin errors++; $display("FAIL full_status got %h exp 00000801", d); end
    nb = 8'($urandom());
    addr = ADDR_TXDATA; wdata = {24'h0, nb}; wstrb = 4'b0001; wen = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    wen = 1'b0; wstrb = 4'h0; tx_ready = 1'b0;
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0000_0801) begin errors++; $display("FAIL push_pop_full_status got %h exp 00000801", d); end
    for (int i = 1; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(nb);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[i])
        begin errors++; $display("FAIL push_pop_order_%0d got v=%b %h exp v=1 %h", i, tx_valid, tx_data, exp_q[i]); end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL push_pop_empty got %b exp 0", tx_valid); end
  endtask

  task automatic test_fifo_random();
    logic [7:0]  q [$];
    logic        ovf_m;
    logic [7:0]  b;
    logic [31:0] d;
    int          act;
    logic        rdy, pop_m, full_pre;
    ovf_m = 1'b0;
    for (int n = 0; n < 300; n++) begin
      act = $urandom_range(0, 5);
      rdy = ($urandom_range(0, 2) == 0);
      tx_ready = rdy;
      checks++; if (tx_valid !== (q.size() != 0))
        begin errors++; $display("FAIL rnd_valid cycle %0d got %b exp %0d", n, tx_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (tx_data !== q[0]) begin errors++; $display("FAIL rnd_head cycle %0d got %h exp %h", n, tx_data, q[0]); end
      end
      b = 8'($urandom());
      if (act < 4) begin
        d = $urandom(); d[7:0] = b;
        addr = ADDR_TXDATA; wdata = d; wstrb = 4'b0001; wen = 1'b1;
      end else if (act == 4) begin
        bus_read(ADDR_STATUS, d);
        checks++; if (d !== exp_status(q.size(), ovf_m))
          begin errors++; $display("FAIL rnd_status cycle %0d got %h exp %h", n, d, exp_status(q.size(), ovf_m)); end
      end else begin
        addr = ADDR_STATUS; wdata = 32'h4; wstrb = 4'b0001; wen = 1'b1;
      end
      pop_m    = (q.size() != 0) && rdy;
      full_pre = (q.size() == TXQ_DEPTH);
      if (pop_m) void'(q.pop_front());
      if (act < 4) begin
        if (!full_pre || pop_m) q.push_back(b);
        else ovf_m = 1'b1;
      end else if (act == 5) begin
        ovf_m = 1'b0;
      end
      @(negedge clk);
      wen = 1'b0; wstrb = 4'h0;
    end
    tx_ready = 1'b1;
    repeat (TXQ_DEPTH + 1) @(negedge clk);
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rnd_final_drain got %b exp 0", tx_valid); end
    bus_write(ADDR_STATUS, 32'h4, 4'b0001);
  endtask

  task automatic test_mtime_wrap();
    logic [31:0] lo, hi;
    bus_write(ADDR_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    bus_write(ADDR_MTIME_HI, 32'h0, 4'hF);
    bus_read(ADDR_MTIME_LO, lo);
    bus_read(ADDR_MTIME_HI, hi);
    checks++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFE)
      begin errors++; $display("FAIL mtime_write_holds got %h_%h exp 00000000_fffffffe", hi, lo); end
    @(negedge clk);
    @(negedge clk);
    bus_read(ADDR_MTIME_HI, hi);
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL mtime_carry_hi got %h exp 00000001", hi); end
    bus_read(ADDR_MTIME_LO, lo);
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mtime_carry_lo got %h exp 0", lo); end
    // Single-byte write into the high half; low half must not advance that cycle
    bus_write(ADDR_MTIME_HI, 32'h1122_3344, 4'b0010);
    bus_read(ADDR_MTIME_HI, hi);
    bus_read(ADDR_MTIME_LO, lo);
    checks++; if ({hi, lo} !== 64'h0000_3301_0000_0000)
      begin errors++; $display("FAIL mtime_byte_write got %h_%h exp 00003301_00000000", hi, lo); end
  endtask

  task automatic test_irq();
    logic [31:0] lo, hi;
    do_reset();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_reset got %b exp 0", irq); end
    bus_write(ADDR_MTCMP_LO, 32'h0, 4'hF);
    bus_write(ADDR_MTCMP_HI, 32'h0, 4'hF);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b exp 0", irq); end
    bus_read(ADDR_MTCMP_LO, lo);
    bus_read(ADDR_MTCMP_HI, hi);
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL mtcmp_readback got %h_%h exp 0", hi, lo); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
    bus_write(ADDR_MTCMP_HI, 32'hFFFF_FFFF, 4'hF);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b exp 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
  endtask

  task automatic test_irq_random();
    logic [63:0] m, c, t;
    logic [31:0] lo, hi;
    for (int it = 0; it < 8; it++) begin
      m = {$urandom(), $urandom()};
      if (it == 0) m = 64'hFFFF_FFFF_FFFF_FFFD;
      if (it == 1) m = 64'h0000_0000_FFFF_FFFE;
      c = m + 64'($urandom_range(0, 6)) - 64'd3;
      bus_write(ADDR_MTCMP_LO, c[31:0], 4'hF);
      bus_write(ADDR_MTCMP_HI, c[63:32], 4'hF);
      bus_write(ADDR_MTIME_LO, m[31:0], 4'hF);
      bus_write(ADDR_MTIME_HI, m[63:32], 4'hF);
      for (int j = 1; j <= 4; j++) begin
        @(negedge clk);
        t = m + 64'(j - 1);
        checks++; if (irq !== (t >= c))
          begin errors++; $display("FAIL irq_rnd it %0d step %0d got %b exp %b (mtime %h cmp %h)", it, j, irq, t >= c, t, c); end
      end
      bus_read(ADDR_MTIME_LO, lo);
      bus_read(ADDR_MTIME_HI, hi);
      t = m + 64'd4;
      checks++; if ({hi, lo} !== t) begin errors++; $display("FAIL mtime_rnd it %0d got %h_%h exp %h", it, hi, lo, t); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d;
    tx_ready = 1'b0;
    bus_write(32'(4*(RAM_WORDS - 2)), 32'h5A5A_A5A5, 4'hF);
    for (int i = 0; i < 3; i++) bus_write(ADDR_TXDATA, 32'(8'hA0 + i), 4'b0001);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", tx_valid); end
    #20;
    rstn = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL async_reset_data got %h exp 00", tx_data); end
    #(2*HALF);
    @(negedge clk);
    rstn = 1'b1;
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL post_reset_status got %h exp 00000002", d); end
    bus_read(32'(4*(RAM_WORDS - 2)), d);
    checks++; if (d !== 32'h5A5A_A5A5) begin errors++; $display("FAIL ram_kept_over_reset got %h exp 5a5aa5a5", d); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b exp 0", tx_valid); end
  endtask

  initial begin
    #(2*HALF*20000);
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    test_reset();
    test_ram_strobe();
    test_ram_random();
    test_fifo_overflow();
    test_full_push_pop();
    test_fifo_random();
    test_mtime_wrap();
    test_irq();
    test_irq_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
